// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
// Also holds the NOP select encoding driven on CU_S.
package hazard_stall_controller_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_G0 = 5'd0;

    // CU_S mux select: PASS forwards decoded control, NOP forces a bubble into ID/EX
    localparam logic CU_S_PASS = 1'b0;
    localparam logic CU_S_NOP  = 1'b1;

    localparam int MC_CNT_W = 4;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// ID/EX hazard sideband in from the pipeline, front-end enables out.
// The master side drives the operand/EX info; the slave is the controller.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic [4:0]       ID_rd;
    logic             ID_uses_rs1;
    logic             ID_uses_rs2;
    logic             ID_uses_rd;
    logic             ID_multicycle;
    logic             ID_annul;
    logic             EX_load;
    logic             EX_Register_File_Enable;
    logic [4:0]       EX_RD;
    logic             nPC_LE;
    logic             PC_LE;
    logic             IF_ID_LE;
    logic             CU_S;
    logic             IF_ID_flush;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ID_rs1, ID_rs2, ID_rd, ID_uses_rs1, ID_uses_rs2, ID_uses_rd,
               ID_multicycle, ID_annul, EX_load, EX_Register_File_Enable, EX_RD,
        input  nPC_LE, PC_LE, IF_ID_LE, CU_S, IF_ID_flush, mc_busy, stall_cycles
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rd, ID_uses_rs1, ID_uses_rs2, ID_uses_rd,
               ID_multicycle, ID_annul, EX_load, EX_Register_File_Enable, EX_RD,
        output nPC_LE, PC_LE, IF_ID_LE, CU_S, IF_ID_flush, mc_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose result an ID operand needs.
// Kept standalone so the store-data path can reuse it.
module load_use_detect
    import hazard_stall_controller_pkg::*;
(
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic [4:0] i_rd,
    input  logic       i_uses_rs1,
    input  logic       i_uses_rs2,
    input  logic       i_uses_rd,
    input  logic       i_ex_load,
    input  logic       i_ex_rf_en,
    input  logic [4:0] i_ex_rd,
    output logic       o_load_hz
);
    logic w_ex_writes;
    logic w_match;

    // %g0 is hardwired zero, so a load targeting it never produces a value to wait for
    assign w_ex_writes = i_ex_load & i_ex_rf_en & (i_ex_rd != REG_G0);
    assign w_match     = (i_uses_rs1 & (i_rs1 == i_ex_rd))
                       | (i_uses_rs2 & (i_rs2 == i_ex_rd))
                       | (i_uses_rd  & (i_rd  == i_ex_rd));
    assign o_load_hz   = w_ex_writes & w_match;

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage front-end sequencer: load-use bubbles, multicycle freeze, delay-slot annul.
// Outputs are combinational from registered state so a stall acts in the detect cycle.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    hazard_stall_controller_if.slave   bus
);
    localparam logic [MC_CNT_W-1:0] MC_INIT  = MC_CNT_W'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

    state_e                r_state;
    state_e                w_next_state;
    logic [MC_CNT_W-1:0]   r_mc_cnt;
    logic [CNT_W-1:0]      r_stall_cycles;

    logic w_load_hz;
    logic w_le;
    logic w_cu_s;
    logic w_flush;
    logic w_busy;
    logic w_mc_issue;

    load_use_detect u_load_use_detect (
        .i_rs1      (bus.ID_rs1),
        .i_rs2      (bus.ID_rs2),
        .i_rd       (bus.ID_rd),
        .i_uses_rs1 (bus.ID_uses_rs1),
        .i_uses_rs2 (bus.ID_uses_rs2),
        .i_uses_rd  (bus.ID_uses_rd),
        .i_ex_load  (bus.EX_load),
        .i_ex_rf_en (bus.EX_Register_File_Enable),
        .i_ex_rd    (bus.EX_RD),
        .o_load_hz  (w_load_hz)
    );

    always_comb begin
        w_le         = 1'b1;
        w_cu_s       = CU_S_PASS;
        w_flush      = 1'b0;
        w_busy       = 1'b0;
        w_mc_issue   = 1'b0;
        w_next_state = r_state;
        // Reset forces the run-state view regardless of what the pipeline presents
        if (!reset) begin
            unique case (r_state)
                RUN: begin
                    if (w_load_hz) begin
                        w_le   = 1'b0;
                        w_cu_s = CU_S_NOP;
                    end else begin
                        w_flush = bus.ID_annul;
                        if (bus.ID_multicycle) begin
                            w_mc_issue   = 1'b1;
                            w_next_state = MC_WAIT;
                        end
                    end
                end
                MC_WAIT: begin
                    w_le   = 1'b0;
                    w_cu_s = CU_S_NOP;
                    w_busy = 1'b1;
                    if (r_mc_cnt == MC_CNT_W'(1)) w_next_state = RUN;
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_mc_issue)            r_mc_cnt <= MC_INIT;
            else if (r_state == MC_WAIT) r_mc_cnt <= r_mc_cnt - MC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                              r_stall_cycles <= '0;
        else if (!w_le && r_stall_cycles != CNT_MAX) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end

    assign bus.nPC_LE       = w_le;
    assign bus.PC_LE        = w_le;
    assign bus.IF_ID_LE     = w_le;
    assign bus.CU_S         = w_cu_s;
    assign bus.IF_ID_flush  = w_flush;
    assign bus.mc_busy      = w_busy;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MC_LATENCY=4, CNT_W=4 to reach saturation).
module tb_hazard_stall_controller;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_controller #(.MC_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.ID_rs1 = 5'd0; bus.ID_rs2 = 5'd0; bus.ID_rd = 5'd0;
        bus.ID_uses_rs1 = 1'b0; bus.ID_uses_rs2 = 1'b0; bus.ID_uses_rd = 1'b0;
        bus.ID_multicycle = 1'b0; bus.ID_annul = 1'b0;
        bus.EX_load = 1'b0; bus.EX_Register_File_Enable = 1'b0; bus.EX_RD = 5'd0;
    endtask

    task automatic hazard_r5();
        bus.EX_load = 1'b1; bus.EX_Register_File_Enable = 1'b1; bus.EX_RD = 5'd5;
        bus.ID_rs1 = 5'd5; bus.ID_uses_rs1 = 1'b1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        tick();
        // reset view holds even with a live hazard on the inputs
        hazard_r5();
        #1;
        chk("rst_pc_le",  32'(bus.PC_LE), 1);
        chk("rst_npc_le", 32'(bus.nPC_LE), 1);
        chk("rst_cu_s",   32'(bus.CU_S), 0);
        chk("rst_busy",   32'(bus.mc_busy), 0);
        tick();
        chk("rst_stall",  32'(bus.stall_cycles), 0);

        // 1: load then dependent
        reset = 1'b0;
        #1;
        chk("ld_pc_le",    32'(bus.PC_LE), 0);
        chk("ld_ifid_le",  32'(bus.IF_ID_LE), 0);
        chk("ld_cu_s",     32'(bus.CU_S), 1);
        chk("ld_stall0",   32'(bus.stall_cycles), 0);
        tick();
        chk("ld_stall1",   32'(bus.stall_cycles), 1);
        bus.EX_load = 1'b0;
        #1;
        chk("ld_resume",   32'(bus.PC_LE), 1);
        chk("ld_cu_s_off", 32'(bus.CU_S), 0);

        // 2: %g0, unused operand, rf disabled, store-data rd hazard
        clear_in();
        bus.EX_load = 1'b1; bus.EX_Register_File_Enable = 1'b1; bus.EX_RD = 5'd0;
        bus.ID_rs1 = 5'd0; bus.ID_uses_rs1 = 1'b1;
        #1;
        chk("g0_no_stall", 32'(bus.PC_LE), 1);
        bus.ID_uses_rs1 = 1'b0; bus.EX_RD = 5'd7; bus.ID_rs2 = 5'd7; bus.ID_uses_rs2 = 1'b0;
        #1;
        chk("unused_rs2",  32'(bus.PC_LE), 1);
        bus.ID_uses_rs2 = 1'b1; bus.EX_Register_File_Enable = 1'b0;
        #1;
        chk("no_rf_en",    32'(bus.PC_LE), 1);
        bus.ID_uses_rs2 = 1'b0; bus.EX_Register_File_Enable = 1'b1;
        bus.ID_rd = 5'd7; bus.ID_uses_rd = 1'b1;
        #1;
        chk("rd_hz",       32'(bus.PC_LE), 0);
        tick();
        chk("rd_stall2",   32'(bus.stall_cycles), 2);

        // 3: multicycle freeze of MC_LATENCY-1 cycles; ID_multicycle held is ignored in wait
        clear_in();
        bus.ID_multicycle = 1'b1;
        #1;
        chk("mc_issue_le",   32'(bus.PC_LE), 1);
        chk("mc_issue_cu_s", 32'(bus.CU_S), 0);
        chk("mc_issue_busy", 32'(bus.mc_busy), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) bus.ID_multicycle = 1'b0;
            #1;
            chk("mc_wait_busy", 32'(bus.mc_busy), 1);
            chk("mc_wait_le",   32'(bus.PC_LE), 0);
            chk("mc_wait_cu_s", 32'(bus.CU_S), 1);
        end
        tick();
        chk("mc_done_busy",  32'(bus.mc_busy), 0);
        chk("mc_done_le",    32'(bus.PC_LE), 1);
        chk("mc_stall5",     32'(bus.stall_cycles), 5);

        // load_hz outranks multicycle, then reset in the second wait cycle
        hazard_r5();
        bus.ID_multicycle = 1'b1;
        #1;
        chk("hzmc_le",   32'(bus.PC_LE), 0);
        chk("hzmc_busy", 32'(bus.mc_busy), 0);
        tick();
        bus.EX_load = 1'b0;
        #1;
        chk("hzmc_issue", 32'(bus.PC_LE), 1);
        tick();
        chk("hzmc_wait1", 32'(bus.mc_busy), 1);
        chk("hzmc_stall", 32'(bus.stall_cycles), 6);
        tick();
        chk("hzmc_wait2", 32'(bus.mc_busy), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bus.mc_busy), 0);
        chk("rst_mid_le",   32'(bus.PC_LE), 1);
        tick();
        reset = 1'b0;
        bus.ID_multicycle = 1'b0;
        #1;
        chk("post_rst_busy",  32'(bus.mc_busy), 0);
        chk("post_rst_le",    32'(bus.IF_ID_LE), 1);
        chk("post_rst_stall", 32'(bus.stall_cycles), 0);

        // 4: annul deferred by a stall, then honoured
        hazard_r5();
        bus.ID_annul = 1'b1;
        #1;
        chk("annul_hz_flush", 32'(bus.IF_ID_flush), 0);
        chk("annul_hz_le",    32'(bus.PC_LE), 0);
        tick();
        bus.EX_load = 1'b0;
        #1;
        chk("annul_flush",    32'(bus.IF_ID_flush), 1);
        chk("annul_le",       32'(bus.PC_LE), 1);
        chk("annul_stall1",   32'(bus.stall_cycles), 1);
        bus.ID_annul = 1'b0;
        #1;
        chk("annul_off",      32'(bus.IF_ID_flush), 0);

        // 6: saturation at 2^CNT_W-1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hazard_r5();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) chk("sat_reach15", 32'(bus.stall_cycles), 15);
        end
        chk("sat_hold15", 32'(bus.stall_cycles), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
